karat_mult_pipe: RTL and testbench
==================================

// Module: karat_mult_pipe
// PURPOSE
//  Parametrised, pipelined Karatsuba multiplier for arbitrary operand width.
//  Accepts one operand pair per cycle over a valid/ready handshake; per-transaction signed/unsigned mode.
//  Carries a user tag alongside each product.
//  Drop-in arithmetic core for wide modular-multiply datapaths; replaces the fixed power-of-two, unhandshaked recursive multiplier.
// PARAMETERS
//  WI     16  operand width, >=2, need not be a power of two
//  LEVELS 2   Karatsuba recursion depth; 0 = native '*' only; requires WI>>LEVELS >= 1
//  TAG_W  4   width of the pass-through transaction tag, >=1
// PORTS
//  clk       in  1      clock, rising edge
//  rst_n     in  1      asynchronous active-low reset
//  i_valid   in  1      operand pair valid
//  i_ready   out 1      block can accept this cycle
//  i_signed  in  1      1: iX/iY are two's complement; 0: unsigned
//  iX        in  WI     operand X
//  iY        in  WI     operand Y
//  i_tag     in  TAG_W  user tag, returned unchanged with the product
//  o_valid   out 1      product valid
//  o_ready   in  1      downstream accepts product
//  oO        out 2*WI   product, signed or unsigned per the transaction's i_signed
//  o_tag     out TAG_W  tag of the transaction on oO
// BEHAVIOUR
//  Reset: all pipeline valid bits=0, o_valid=0, oO=0, o_tag=0; i_ready=1 out of reset. Pipeline data regs need not reset.
//  Handshake: input accepted when i_valid&&i_ready; output consumed when o_valid&&o_ready.
//   Payload and o_valid are held stable while o_valid&&!o_ready.
//  Stall: global advance = !(o_valid&&!o_ready); i_ready = advance (combinational from o_valid, o_ready only).
//   Stalled pipeline holds all stages; no bubble squeezing.
//  Latency: exactly LAT=LEVELS+2 advancing cycles from acceptance to o_valid. Throughput: 1 per cycle when o_ready=1.
//  Stage S0 (input reg): capture iX, iY, i_tag, i_signed.
//   If signed, form magnitudes |iX|, |iY| (WI-bit unsigned; -2^(WI-1) maps to 2^(WI-1)) and neg = sx^sy.
//  Stages S1..S_LEVELS: one register boundary per recursion level, splitting operands as WLO=w/2 (floor), WHI=w-WLO.
//   p=Xhi*Yhi, q=Xlo*Ylo, m=(Xhi+Xlo)*(Yhi+Ylo) using the full (WHI+1)-bit sums.
//   Recombine: P = p<<(2*WLO) + (m-p-q)<<WLO + q.
//   Leaf (remaining depth 0): native '*'. No intermediate truncation; every sum sized for carry.
//  Final stage: oO = neg ? -P : P, modulo 2^(2*WI). Unsigned: oO = P exactly.
//  Valid, tag and neg travel in a shift chain of LAT entries, advancing with the global enable.
//  Reset mid-operation: all in-flight transactions discarded, o_valid=0 asynchronously; no output for them after release.
//  Simultaneous consume and accept: allowed in the same cycle at full throughput.
//  i_signed sampled only on acceptance; mixing modes back-to-back is legal.
//  Elaboration: $error if WI<2, TAG_W<1, or (WI>>LEVELS)<1.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream, hold 3 cycles -> o_valid=0, oO=0, i_ready=1; no stale output after release.
//  T2 WI=8,LEVELS=2, unsigned 255*255, tag=5, o_ready=1 -> oO=16'hFE01, o_tag=5, o_valid exactly 4 cycles after accept.
//  T3 WI=8 signed -128*127 -> oO=16'hC080; signed -1*-1 -> 16'h0001; back-to-back with unsigned 255*1 -> 16'h00FF.
//  T4 backpressure: stream 10 pairs with o_ready toggling randomly -> i_ready tracks stall, no loss/dup, order and tags kept.
//  T5 odd width WI=13,LEVELS=2: 8191*8191 unsigned -> oO=26'h3FFC001; 10k random pairs match reference model, both modes.
//  T6 LEVELS=0, WI=16: latency 2, 65535*65535 -> 32'hFFFE0001.

Source files
------------

// File: rtl/karat_mult_pipe.sv
// Pipelined Karatsuba multiplier with valid/ready handshake, per-transaction signed mode and tag pass-through.
// One register boundary per recursion level between the input stage and the final sign-fix stage.
module karat_mult_pipe #(
    parameter int WI     = 16,
    parameter int LEVELS = 2,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic                i_signed,
    input  logic [WI-1:0]       iX,
    input  logic [WI-1:0]       iY,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [2*WI-1:0]     oO,
    output logic [TAG_W-1:0]    o_tag
);
    localparam int LAT = LEVELS + 2;
    localparam int W2  = 2 * WI;

    if (WI < 2) begin : g_bad_wi
        $error("karat_mult_pipe: WI must be >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("karat_mult_pipe: TAG_W must be >= 1");
    end
    if ((WI >> LEVELS) < 1) begin : g_bad_levels
        $error("karat_mult_pipe: WI >> LEVELS must be >= 1");
    end

    logic                       adv;
    logic [LAT-1:0]             vld_q;
    logic [LAT-1:0][TAG_W-1:0]  tag_q;
    logic [LAT-2:0]             neg_q;
    logic [WI-1:0]              mx_d, my_d, mx_q, my_q;
    logic                       neg_d;
    logic [W2-1:0]              prod;
    logic [W2-1:0]              prod_d, oO_q;

    // Whole pipeline freezes only while a finished product waits for the consumer.
    assign adv     = !(o_valid && !o_ready);
    assign i_ready = adv;

    // The most negative value wraps to 2^(WI-1), which is the correct unsigned magnitude.
    assign mx_d  = (i_signed && iX[WI-1]) ? -iX : iX;
    assign my_d  = (i_signed && iY[WI-1]) ? -iY : iY;
    assign neg_d = i_signed && (iX[WI-1] ^ iY[WI-1]);

    // NOTE: datapath registers carry no reset; only valid/tag/sign/output state must be defined after reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            mx_q <= mx_d;
            my_q <= my_d;
        end
    end

    // NOTE: non-blocking assignments let every chain entry read its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
            neg_q <= '0;
        end else if (adv) begin
            vld_q[0] <= i_valid;
            tag_q[0] <= i_tag;
            neg_q[0] <= neg_d;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            for (int k = 1; k < LAT - 1; k++) begin
                neg_q[k] <= neg_q[k-1];
            end
        end
    end

    if (LEVELS == 0) begin : g_native
        karat_leaf #(.W(WI)) u_leaf (
            .x_i (mx_q),
            .y_i (my_q),
            .p_o (prod)
        );
    end else begin : g_karat
        karat_node #(.W(WI), .DEPTH(LEVELS)) u_root (
            .clk  (clk),
            .en_i (adv),
            .x_i  (mx_q),
            .y_i  (my_q),
            .p_o  (prod)
        );
    end

    assign prod_d = neg_q[LAT-2] ? -prod : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oO_q <= '0;
        end else if (adv) begin
            oO_q <= prod_d;
        end
    end

    assign oO      = oO_q;
    assign o_valid = vld_q[LAT-1];
    assign o_tag   = tag_q[LAT-1];
endmodule

// One Karatsuba level: registers the split halves and carry-wide sums, then recombines the three sub-products.
module karat_node #(
    parameter int W     = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    output logic [2*W-1:0]   p_o
);
    localparam int WLO = W / 2;
    localparam int WHI = W - WLO;
    localparam int WS  = WHI + 1;
    localparam int WM  = 2 * WS;
    localparam int W2  = 2 * W;

    logic [WHI-1:0]   xh_q, yh_q;
    logic [WLO-1:0]   xl_q, yl_q;
    logic [WS-1:0]    xs_q, ys_q;
    logic [2*WHI-1:0] p_hh;
    logic [2*WLO-1:0] p_ll;
    logic [WM-1:0]    p_mm, mid;

    always_ff @(posedge clk) begin
        if (en_i) begin
            xh_q <= x_i[W-1:WLO];
            xl_q <= x_i[WLO-1:0];
            yh_q <= y_i[W-1:WLO];
            yl_q <= y_i[WLO-1:0];
            xs_q <= WS'(x_i[W-1:WLO]) + WS'(x_i[WLO-1:0]);
            ys_q <= WS'(y_i[W-1:WLO]) + WS'(y_i[WLO-1:0]);
        end
    end

    if (DEPTH == 1) begin : g_leaves
        karat_leaf #(.W(WHI)) u_hh (.x_i(xh_q), .y_i(yh_q), .p_o(p_hh));
        karat_leaf #(.W(WLO)) u_ll (.x_i(xl_q), .y_i(yl_q), .p_o(p_ll));
        karat_leaf #(.W(WS))  u_mm (.x_i(xs_q), .y_i(ys_q), .p_o(p_mm));
    end else begin : g_nodes
        karat_node #(.W(WHI), .DEPTH(DEPTH-1)) u_hh (.clk(clk), .en_i(en_i), .x_i(xh_q), .y_i(yh_q), .p_o(p_hh));
        karat_node #(.W(WLO), .DEPTH(DEPTH-1)) u_ll (.clk(clk), .en_i(en_i), .x_i(xl_q), .y_i(yl_q), .p_o(p_ll));
        karat_node #(.W(WS),  .DEPTH(DEPTH-1)) u_mm (.clk(clk), .en_i(en_i), .x_i(xs_q), .y_i(ys_q), .p_o(p_mm));
    end

    // Cross term is never negative and always fits in 2*W bits, so the final truncation is exact.
    assign mid = p_mm - WM'(p_hh) - WM'(p_ll);
    assign p_o = (W2'(p_hh) << (2 * WLO)) + (W2'(mid) << WLO) + W2'(p_ll);
endmodule

// Recursion leaf: full-width native multiply.
module karat_leaf #(
    parameter int W = 2
) (
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    output logic [2*W-1:0]   p_o
);
    localparam int W2 = 2 * W;

    assign p_o = W2'(x_i) * W2'(y_i);
endmodule

// File: tb/tb_karat_mult_pipe.sv
// Scoreboard bench for karat_mult_pipe: three configurations (8/L2, 13/L2, 16/L0) driven one at a time.
// Expected products come from a plain signed/unsigned integer multiply model.
module tb_karat_mult_pipe;
    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
        int          acc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tsgn = 1'b0;
    logic [15:0] tx = '0, ty = '0;
    logic [3:0]  ttag = '0;
    logic        tor = 1'b1;
    logic        bp = 1'b0;
    logic        lat_chk = 1'b1;
    logic        iv8 = 1'b0, iv13 = 1'b0, iv16 = 1'b0;
    logic        rdy8, rdy13, rdy16;
    logic        ov8, ov13, ov16;
    logic [15:0] o8;
    logic [25:0] o13;
    logic [31:0] o16;
    logic [3:0]  ot8, ot13, ot16;

    sb_t q8[$], q13[$], q16[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    logic        hold_p = 1'b0;
    logic [15:0] hold_o = '0;
    logic [3:0]  hold_t = '0;

    karat_mult_pipe #(.WI(8), .LEVELS(2), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv8), .i_ready(rdy8), .i_signed(tsgn),
        .iX(tx[7:0]), .iY(ty[7:0]), .i_tag(ttag),
        .o_valid(ov8), .o_ready(tor), .oO(o8), .o_tag(ot8)
    );
    karat_mult_pipe #(.WI(13), .LEVELS(2), .TAG_W(4)) dut13 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv13), .i_ready(rdy13), .i_signed(tsgn),
        .iX(tx[12:0]), .iY(ty[12:0]), .i_tag(ttag),
        .o_valid(ov13), .o_ready(tor), .oO(o13), .o_tag(ot13)
    );
    karat_mult_pipe #(.WI(16), .LEVELS(0), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv16), .i_ready(rdy16), .i_signed(tsgn),
        .iX(tx), .iY(ty), .i_tag(ttag),
        .o_valid(ov16), .o_ready(tor), .oO(o16), .o_tag(ot16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        tor = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic sgn, input int wi);
        longint a, b, p, m;
        m = (longint'(1) << wi) - 1;
        a = longint'(x) & m;
        b = longint'(y) & m;
        if (sgn && a[wi-1]) a = a - (longint'(1) << wi);
        if (sgn && b[wi-1]) b = b - (longint'(1) << wi);
        p = a * b;
        return 32'(p & ((longint'(1) << (2 * wi)) - 1));
    endfunction

    function automatic logic rdy_of(input int d);
        case (d)
            0:       return rdy8;
            1:       return rdy13;
            default: return rdy16;
        endcase
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [15:0] x, input logic [15:0] y,
                        input logic sgn, input logic [3:0] tag);
        int n = 0;
        tx = x; ty = y; tsgn = sgn; ttag = tag;
        iv8 = (d == 0); iv13 = (d == 1); iv16 = (d == 2);
        forever begin
            @(negedge clk);
            if (rdy_of(d)) begin
                case (d)
                    0:       q8.push_back('{ref_mul(x, y, sgn, 8), tag, cyc});
                    1:       q13.push_back('{ref_mul(x, y, sgn, 13), tag, cyc});
                    default: q16.push_back('{ref_mul(x, y, sgn, 16), tag, cyc});
                endcase
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(n), 64'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv8 = 1'b0; iv13 = 1'b0; iv16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() + q13.size() + q16.size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 64'(q8.size() + q13.size() + q16.size()), 64'(0));
    endtask

    task automatic mon(input int d, input logic [31:0] got, input logic [3:0] gtag, input int lat);
        sb_t e;
        int  sz;
        case (d)
            0:       sz = q8.size();
            1:       sz = q13.size();
            default: sz = q16.size();
        endcase
        if (sz == 0) begin
            check($sformatf("spurious_d%0d", d), 64'(got), 64'hDEAD_0000_0000_0000);
        end else begin
            case (d)
                0:       e = q8.pop_front();
                1:       e = q13.pop_front();
                default: e = q16.pop_front();
            endcase
            check($sformatf("prod_d%0d", d), 64'(got), 64'(e.prod));
            check($sformatf("tag_d%0d", d), 64'(gtag), 64'(e.tag));
            if (lat_chk) check($sformatf("lat_d%0d", d), 64'(cyc - e.acc), 64'(lat));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8 && tor)  mon(0, {16'h0, o8}, ot8, 4);
            if (ov13 && tor) mon(1, {6'h0, o13}, ot13, 4);
            if (ov16 && tor) mon(2, o16, ot16, 2);
            check("ready_d0", 64'(rdy8), 64'(!(ov8 && !tor)));
            if (hold_p) check("hold_d0", {43'h0, ov8, ot8, o8}, {43'h0, 1'b1, hold_t, hold_o});
            hold_p <= ov8 && !tor;
            hold_o <= o8;
            hold_t <= ot8;
        end else begin
            hold_p <= 1'b0;
        end
    end

    task automatic check_reset_state();
        check("rst_valid_d0", 64'(ov8), 64'(0));
        check("rst_out_d0", 64'(o8), 64'(0));
        check("rst_tag_d0", 64'(ot8), 64'(0));
        check("rst_ready_d0", 64'(rdy8), 64'(1));
        check("rst_valid_d1", 64'(ov13), 64'(0));
        check("rst_out_d1", 64'(o13), 64'(0));
        check("rst_valid_d2", 64'(ov16), 64'(0));
        check("rst_ready_d2", 64'(rdy16), 64'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic unsigned corner with latency.
        send(0, 16'h00FF, 16'h00FF, 1'b0, 4'd5);
        idle();
        drain();

        // Signed corners back-to-back with an unsigned transaction.
        send(0, 16'h0080, 16'h007F, 1'b1, 4'd1);
        send(0, 16'h00FF, 16'h00FF, 1'b1, 4'd2);
        send(0, 16'h00FF, 16'h0001, 1'b0, 4'd3);
        send(0, 16'h0080, 16'h0080, 1'b1, 4'd4);
        idle();
        drain();

        // Native-only configuration.
        send(2, 16'hFFFF, 16'hFFFF, 1'b0, 4'd6);
        send(2, 16'h8000, 16'h8000, 1'b1, 4'd7);
        send(2, 16'h8000, 16'h7FFF, 1'b1, 4'd8);
        idle();
        drain();

        // Odd width: corners then a long random stream in both modes.
        send(1, 16'h1FFF, 16'h1FFF, 1'b0, 4'd8);
        send(1, 16'h1000, 16'h1000, 1'b1, 4'd9);
        send(1, 16'h1FFF, 16'h0FFF, 1'b1, 4'd10);
        for (int i = 0; i < 10000; i++) begin
            send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle();
        drain();

        // Random backpressure on the consumer side.
        lat_chk = 1'b0;
        bp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(0, 16'(i * 23 + 7), 16'(255 - i * 11), 1'(i % 2), 4'(i));
        end
        for (int i = 0; i < 200; i++) begin
            send(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 60; i++) begin
            send(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle();
        drain();
        bp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lat_chk = 1'b1;

        // Reset mid-stream: in-flight work must vanish without a trace.
        send(0, 16'h0011, 16'h0022, 1'b0, 4'd1);
        send(0, 16'h0033, 16'h0044, 1'b0, 4'd2);
        send(0, 16'h0055, 16'h0066, 1'b1, 4'd3);
        idle();
        rst_n = 1'b0;
        #1;
        check("async_valid_d0", 64'(ov8), 64'(0));
        q8.delete();
        q13.delete();
        q16.delete();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(0, 16'h0003, 16'h0005, 1'b0, 4'd9);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
